// File: rtl/data_sram_if.sv
// Memory request/response bus between the load/store unit (master) and the
// data memory (slave).
//   mem_valid_i  request valid               (master -> slave)
//   mem_ready_o  slave can accept a request  (slave  -> master)
//   mem_addr_i   byte address                (master -> slave)
//   mem_wdata_i  lane-aligned write data     (master -> slave)
//   mem_wmask_i  byte write enables, 0=read  (master -> slave)
//   mem_rdata_o  read data, 0 unless rvalid  (slave  -> master)
//   mem_rvalid_o one-cycle response pulse    (slave  -> master)
interface data_sram_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wmask_i;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    input  mem_ready_o, mem_rdata_o, mem_rvalid_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    output mem_ready_o, mem_rdata_o, mem_rvalid_o
  );
endinterface

// File: rtl/data_sram.sv
// Single-ported word-organised data memory for the load/store unit.
// One request at a time on a valid/ready handshake; byte-masked writes or
// word reads; every accepted request gets exactly one response pulse after
// LATENCY cycles (writes respond with rdata=0).
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   bus     data_sram_if.slave request/response bus
module data_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  data_sram_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          ready;
  logic          accept;
  logic          is_write;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;

  // ready is gated by reset and never looks at valid
  assign ready    = rst_ni && (state_q == IDLE);
  assign accept   = ready && bus.mem_valid_i;
  assign is_write = |bus.mem_wmask_i;

  // wrapping subtraction makes addresses below BASE_ADDR land far out of range
  assign offset   = bus.mem_addr_i - BASE_ADDR;
  assign in_range = {1'b0, offset} < LIMIT;
  assign idx      = offset[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) rdata_q <= (!is_write && in_range) ? mem[idx] : '0;
    end
  end

  // Storage is not reset; writes commit at the accept edge, so a later reset
  // cannot undo them.
  always_ff @(posedge clk_i) begin
    if (accept && is_write && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.mem_wmask_i[b]) mem[idx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready_o  = ready;
  assign bus.mem_rvalid_o = rst_ni && (state_q == RESP);
  assign bus.mem_rdata_o  = bus.mem_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_data_sram.sv
module tb_data_sram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  int          sel = 0;

  logic        ready, rvalid;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_sram_if if0 ();
  data_sram_if if1 ();
  data_sram_if if2 ();
  data_sram_if if3 ();

  assign if0.mem_valid_i = valid && (sel == 0);
  assign if1.mem_valid_i = valid && (sel == 1);
  assign if2.mem_valid_i = valid && (sel == 2);
  assign if3.mem_valid_i = valid && (sel == 3);
  assign if0.mem_addr_i = addr;  assign if0.mem_wdata_i = wdata;  assign if0.mem_wmask_i = wmask;
  assign if1.mem_addr_i = addr;  assign if1.mem_wdata_i = wdata;  assign if1.mem_wmask_i = wmask;
  assign if2.mem_addr_i = addr;  assign if2.mem_wdata_i = wdata;  assign if2.mem_wmask_i = wmask;
  assign if3.mem_addr_i = addr;  assign if3.mem_wdata_i = wdata;  assign if3.mem_wmask_i = wmask;

  // inst 0: default; inst 1: LATENCY=4; inst 2: small window at 0x1000; inst 3: LATENCY=3
  data_sram u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  data_sram #(.LATENCY(4)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  data_sram #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(2))
    u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
  data_sram #(.LATENCY(3)) u_dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

  always_comb begin
    ready  = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    case (sel)
      0: begin ready = if0.mem_ready_o; rvalid = if0.mem_rvalid_o; rdata = if0.mem_rdata_o; end
      1: begin ready = if1.mem_ready_o; rvalid = if1.mem_rvalid_o; rdata = if1.mem_rdata_o; end
      2: begin ready = if2.mem_ready_o; rvalid = if2.mem_rvalid_o; rdata = if2.mem_rdata_o; end
      3: begin ready = if3.mem_ready_o; rvalid = if3.mem_rvalid_o; rdata = if3.mem_rdata_o; end
      default: ;
    endcase
  end

  function automatic int lat_of(input int k);
    case (k)
      1:       return 4;
      2:       return 2;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request on instance k; entered and left at a negedge.
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] exp, input string nm);
    int lat;
    lat   = lat_of(k);
    sel   = k;
    addr  = a;
    wdata = d;
    wmask = m;
    valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    chk({nm, " ready"}, {31'b0, ready}, 32'd1);
    @(posedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      if (c < lat) begin
        chk({nm, " wait"}, {30'b0, ready, rvalid}, 32'd0);
      end else if (c == lat) begin
        chk({nm, " resp"}, {30'b0, ready, rvalid}, 32'd1);
        chk({nm, " rdata"}, rdata, exp);
      end else begin
        chk({nm, " after"}, {30'b0, ready, rvalid}, 32'd2);
      end
    end
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] ref_mem [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc[$];
    int rvc[$];
    logic [31:0] rvd[$];
    int nrv;

    tbl.push_back('{0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        "w10"});
    tbl.push_back('{0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, "r10"});
    tbl.push_back('{0, 32'h20, 32'h11223344, 4'hF, 32'h0,        "w20"});
    tbl.push_back('{0, 32'h20, 32'h0000AA00, 4'h2, 32'h0,        "w20b1"});
    tbl.push_back('{0, 32'h22, 32'h0,        4'h0, 32'h1122AA44, "r20a"});
    tbl.push_back('{0, 32'h20, 32'hBBCC0000, 4'hC, 32'h0,        "w20h1"});
    tbl.push_back('{0, 32'h20, 32'h0,        4'h0, 32'hBBCCAA44, "r20b"});
    tbl.push_back('{2, 32'h103C, 32'h5A5A1234, 4'hF, 32'h0,      "w103c"});
    tbl.push_back('{2, 32'h1040, 32'hFFFFFFFF, 4'hF, 32'h0,      "w1040"});
    tbl.push_back('{2, 32'h1040, 32'h0,        4'h0, 32'h0,      "r1040"});
    tbl.push_back('{2, 32'h0FFC, 32'h0,        4'h0, 32'h0,      "r0ffc"});
    tbl.push_back('{2, 32'h0FFC, 32'h77777777, 4'hF, 32'h0,      "w0ffc"});
    tbl.push_back('{2, 32'h103C, 32'h0,        4'h0, 32'h5A5A1234, "r103c"});
    tbl.push_back('{1, 32'h40, 32'hA0A0A0A0, 4'hF, 32'h0,        "w40"});
    tbl.push_back('{1, 32'h44, 32'hB1B1B1B1, 4'hF, 32'h0,        "w44"});

    // reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        sel = k;
        #1;
        chk("rst outputs", {ready, rvalid, rdata[29:0]}, 32'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      chk("post-rst ready", {31'b0, ready}, 32'd1);
    end
    sel = 0;
    nrv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if0.mem_rvalid_o || if1.mem_rvalid_o || if2.mem_rvalid_o || if3.mem_rvalid_o) nrv++;
    end
    chk("idle no rvalid", nrv, 0);

    foreach (tbl[i]) xact(tbl[i].inst, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].exp, tbl[i].name);

    // back-to-back reads held on valid, LATENCY=4
    sel = 1; addr = 32'h40; wmask = 4'h0; valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc.size() == 1) addr = 32'h44;
      if (acc.size() == 2) valid = 1'b0;
      #1;
      if (rvalid) begin rvc.push_back(c); rvd.push_back(rdata); end
      if (valid && ready) acc.push_back(c);
      @(negedge clk);
    end
    valid = 1'b0;
    chk("bp accepts", acc.size(), 2);
    chk("bp rvalids", rvc.size(), 2);
    if (acc.size() == 2 && rvc.size() == 2) begin
      chk("bp spacing", acc[1] - acc[0], 5);
      chk("bp lat0", rvc[0] - acc[0], 4);
      chk("bp lat1", rvc[1] - acc[1], 4);
      chk("bp data0", rvd[0], 32'hA0A0A0A0);
      chk("bp data1", rvd[1], 32'hB1B1B1B1);
    end

    // reset one cycle after accepting a write, LATENCY=3
    sel = 3; addr = 32'h8; wdata = 32'hCAFEF00D; wmask = 4'hF; valid = 1'b1;
    #1;
    chk("mid ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst outputs", {30'b0, ready, rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid release ready", {31'b0, ready}, 32'd1);
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid) nrv++;
      @(negedge clk);
    end
    chk("mid no rvalid", nrv, 0);
    xact(3, 32'h8, 32'h0, 4'h0, 32'hCAFEF00D, "mid r8");

    // randomized traffic on the 16-word window at 0x1000 against an array model
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom;
      xact(2, 32'h1000 + 32'(w * 4), ref_mem[w], 4'hF, 32'h0, "rnd init");
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, e;
      logic [3:0]  m;
      bit          inr;
      a   = 32'h0FF0 + 32'($urandom_range(0, 24) * 4) + 32'($urandom_range(0, 3));
      d   = $urandom;
      m   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      inr = (a >= 32'h1000) && (a < 32'h1040);
      e   = 32'h0;
      if (m == 4'h0) begin
        if (inr) e = ref_mem[(a - 32'h1000) / 4];
      end else if (inr) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_mem[(a - 32'h1000) / 4][8*b +: 8] = d[8*b +: 8];
      end
      xact(2, a, d, m, e, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram.md
# data_sram

Single-ported, word-organised data memory that serves the load/store unit's memory request port. Accepts one request at a time on a valid/ready handshake, performs byte-masked writes or word reads, and returns a response pulse after a fixed, parameterised latency. Every accepted request gets exactly one response pulse, writes included, because the requester waits for a response on stores as well as loads. It sits directly downstream of the load/store state machine, which handles sub-word alignment, masking and sign extension.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- LATENCY, 1: cycles from accept to response; legal range 1..15.
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- mem_valid_i  input  1  request valid.
- mem_ready_o  output  1  block can accept a request this cycle.
- mem_addr_i  input  32  byte address; bits [1:0] ignored.
- mem_wdata_i  input  32  write data, already lane-aligned by the requester.
- mem_wmask_i  input  4  byte write enables; 4'b0000 means read.
- mem_rdata_o  output  32  read data; valid only while mem_rvalid_o=1, else 32'h0.
- mem_rvalid_o  output  1  one-cycle response pulse.

## Operation
- States:
  - IDLE: mem_ready_o=1.
  - WAIT: counter running, mem_ready_o=0.
  - RESP: mem_rvalid_o=1, mem_ready_o=0.
- Accept:
  - Occurs on the rising edge ending a cycle in which mem_valid_i=1 and mem_ready_o=1.
  - Address, mask and write data are captured at that edge.
  - Inputs are ignored in all other cycles.
- Address decode:
  - offset = mem_addr_i - BASE_ADDR (32-bit, wrapping).
  - In range iff offset < 4*DEPTH_WORDS.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
- Write (mask ≠ 0):
  - Only masked byte lanes are updated, at the accept edge.
  - Unmasked lanes keep their old contents.
  - Response carries mem_rdata_o=32'h0.
- Read (mask = 0):
  - Returns the word as stored at the accept edge.
  - Later writes cannot affect it, because no write can be accepted before the response.
- Out-of-range address:
  - Writes are dropped.
  - Reads return 32'h0.
  - A normal response is still produced.
- Transitions:
  - IDLE: on accept, go to RESP if LATENCY=1. Otherwise go to WAIT with counter=LATENCY-2.
  - WAIT: if counter=0, go to RESP; else decrement the counter.
  - RESP: always go to IDLE.
- Storage is not reset and its power-up contents are undefined. The bench initialises it through writes.

## Timing
- Reset:
  - While rst_ni=0 at a clock edge, state goes to IDLE and the counter and captured request clear.
  - mem_ready_o and mem_rvalid_o are forced 0 combinationally while rst_ni=0.
  - mem_rdata_o=0 while rst_ni=0.
  - mem_ready_o=1 in the first cycle after rst_ni returns to 1.
- Latency:
  - Accept in cycle T gives mem_rvalid_o=1 in cycle T+LATENCY only.
  - mem_ready_o=0 in cycles T+1..T+LATENCY.
  - mem_ready_o=1 again in cycle T+LATENCY+1.
  - Peak throughput is one request per LATENCY+1 cycles.
- mem_ready_o does not depend combinationally on mem_valid_i.
- Response is a single-cycle pulse with no back-pressure; the requester must sample it.
- A request held on mem_valid_i while mem_ready_o=0 is not accepted until mem_ready_o=1.
- Reset mid-operation:
  - An in-flight response is discarded and no rvalid is emitted.
  - A write already committed at its accept edge stays in storage.
- mem_valid_i dropping after accept has no effect.

## Test plan
- Reset then idle: hold rst_ni=0 for 3 cycles, then release -> ready=0, rvalid=0, rdata=0 during reset; ready=1 in the first cycle after release; no rvalid afterwards with valid low.
- Word write/read, LATENCY=1:
  - Write 32'hDEADBEEF, mask 4'b1111, to 0x10 -> rvalid one cycle after accept with rdata=0.
  - Read 0x10 -> rvalid one cycle after accept with rdata=32'hDEADBEEF.
  - Ready is low for exactly one cycle per request.
- Byte and half masks:
  - Write 32'h11223344 to 0x20.
  - Write 32'h0000AA00 with mask 4'b0010 -> read gives 32'h1122AA44.
  - Write 32'hBBCC0000 with mask 4'b1100 -> read gives 32'hBBCCAA44.
- Latency and back-pressure, LATENCY=4:
  - Hold valid high continuously with two queued reads.
  - Second accept occurs exactly 5 cycles after the first.
  - Each rvalid is exactly 4 cycles after its accept and one cycle wide.
- Out-of-range with BASE_ADDR=0x1000, DEPTH_WORDS=16:
  - Write to 0x1040 then read 0x1040 -> both respond and the read returns 0.
  - Read 0x0FFC -> returns 0.
  - Word 0x103C is unchanged.
- Reset mid-flight, LATENCY=3: accept write 32'hCAFEF00D to 0x8, pull rst_ni low in T+1, release -> no rvalid; a subsequent read of 0x8 returns 32'hCAFEF00D.
